// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, register-address width and the
// reserved PC register index used by the pipeline stages.
package cpu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    MOV = 3'b100
  } alu_op_t;

  localparam int          REG_ADDR_W = 4;
  localparam logic [3:0]  PC_REG     = 4'd15;
  localparam alu_op_t     BUBBLE_OP  = ADD;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: MEM result beats WB result beats the stored
// register-file value; R15 (PC) is never forwarded.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int N    = 32,
  parameter int RA_W = REG_ADDR_W
) (
  input  logic [RA_W-1:0] ra,
  input  logic [N-1:0]    rd,
  input  logic            regwrite_m,
  input  logic [RA_W-1:0] wa_m,
  input  logic [N-1:0]    aluresult_m,
  input  logic            regwrite_w,
  input  logic [RA_W-1:0] wa_w,
  input  logic [N-1:0]    result_w,
  output logic [N-1:0]    y
);

  logic not_pc;
  logic hit_m;
  logic hit_w;

  assign not_pc = (ra != RA_W'(PC_REG));
  assign hit_m  = regwrite_m && (wa_m == ra) && not_pc;
  assign hit_w  = regwrite_w && (wa_w == ra) && not_pc;

  always_comb begin
    y = rd;
    if (hit_m) begin
      y = aluresult_m;
    end else if (hit_w) begin
      y = result_w;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush bubbles, stall hold + WB refresh, and
// MEM/WB operand forwarding. Optional perf counters: ID_EX_PERF_CNT_EN.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int N    = 32,
  parameter int RA_W = REG_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_d_i,
  input  logic [2:0]      opcode_d_i,
  input  logic [N-1:0]    rd1_d_i,
  input  logic [N-1:0]    rd2_d_i,
  input  logic [RA_W-1:0] ra1_d_i,
  input  logic [RA_W-1:0] ra2_d_i,
  input  logic [RA_W-1:0] wa_d_i,
  input  logic            regwrite_d_i,
  input  logic [RA_W-1:0] wa_m_i,
  input  logic            regwrite_m_i,
  input  logic [N-1:0]    aluresult_m_i,
  input  logic [RA_W-1:0] wa_w_i,
  input  logic            regwrite_w_i,
  input  logic [N-1:0]    result_w_i,
  output logic            valid_e_o,
  output logic [2:0]      opcode_e_o,
  output logic [N-1:0]    a_e_o,
  output logic [N-1:0]    b_e_o,
  output logic [RA_W-1:0] wa_e_o,
  output logic            regwrite_e_o,
  output logic [15:0]     stall_cnt_o,
  output logic [15:0]     flush_cnt_o
);

  logic            valid_q;
  logic [2:0]      opcode_q;
  logic [N-1:0]    rd1_q;
  logic [N-1:0]    rd2_q;
  logic [RA_W-1:0] ra1_q;
  logic [RA_W-1:0] ra2_q;
  logic [RA_W-1:0] wa_q;
  logic            regwrite_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      opcode_q   <= 3'b000;
      rd1_q      <= '0;
      rd2_q      <= '0;
      ra1_q      <= '0;
      ra2_q      <= '0;
      wa_q       <= '0;
      regwrite_q <= 1'b0;
    end else if (flush_i) begin
      valid_q    <= 1'b0;
      opcode_q   <= BUBBLE_OP;
      rd1_q      <= '0;
      rd2_q      <= '0;
      ra1_q      <= '0;
      ra2_q      <= '0;
      wa_q       <= '0;
      regwrite_q <= 1'b0;
    end else if (stall_i) begin
      // A WB write retiring during the stall would otherwise be lost once it
      // leaves the forwarding window, so fold it into the held operands.
      if (regwrite_w_i && (wa_w_i == ra1_q)) rd1_q <= result_w_i;
      if (regwrite_w_i && (wa_w_i == ra2_q)) rd2_q <= result_w_i;
    end else begin
      valid_q    <= valid_d_i;
      opcode_q   <= opcode_d_i;
      rd1_q      <= rd1_d_i;
      rd2_q      <= rd2_d_i;
      ra1_q      <= ra1_d_i;
      ra2_q      <= ra2_d_i;
      wa_q       <= wa_d_i;
      regwrite_q <= regwrite_d_i & valid_d_i;
    end
  end

  fwd_mux #(.N(N), .RA_W(RA_W)) u_fwd_a (
    .ra          (ra1_q),
    .rd          (rd1_q),
    .regwrite_m  (regwrite_m_i),
    .wa_m        (wa_m_i),
    .aluresult_m (aluresult_m_i),
    .regwrite_w  (regwrite_w_i),
    .wa_w        (wa_w_i),
    .result_w    (result_w_i),
    .y           (a_e_o)
  );

  fwd_mux #(.N(N), .RA_W(RA_W)) u_fwd_b (
    .ra          (ra2_q),
    .rd          (rd2_q),
    .regwrite_m  (regwrite_m_i),
    .wa_m        (wa_m_i),
    .aluresult_m (aluresult_m_i),
    .regwrite_w  (regwrite_w_i),
    .wa_w        (wa_w_i),
    .result_w    (result_w_i),
    .y           (b_e_o)
  );

  assign valid_e_o    = valid_q;
  assign opcode_e_o   = opcode_q;
  assign wa_e_o       = wa_q;
  assign regwrite_e_o = regwrite_q & valid_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (flush_i && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
      if (stall_i && !flush_i && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
  assign flush_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a slot-level reference model;
// honours ID_EX_PERF_CNT_EN for the counter expectations.
module tb_id_ex_stage;

  localparam int N    = 32;
  localparam int RA_W = 4;
  localparam int EW   = 1 + 3 + N + N + RA_W + 1 + 16 + 16;

  logic            clk;
  logic            rst;
  logic            stall_i;
  logic            flush_i;
  logic            valid_d_i;
  logic [2:0]      opcode_d_i;
  logic [N-1:0]    rd1_d_i;
  logic [N-1:0]    rd2_d_i;
  logic [RA_W-1:0] ra1_d_i;
  logic [RA_W-1:0] ra2_d_i;
  logic [RA_W-1:0] wa_d_i;
  logic            regwrite_d_i;
  logic [RA_W-1:0] wa_m_i;
  logic            regwrite_m_i;
  logic [N-1:0]    aluresult_m_i;
  logic [RA_W-1:0] wa_w_i;
  logic            regwrite_w_i;
  logic [N-1:0]    result_w_i;
  logic            valid_e_o;
  logic [2:0]      opcode_e_o;
  logic [N-1:0]    a_e_o;
  logic [N-1:0]    b_e_o;
  logic [RA_W-1:0] wa_e_o;
  logic            regwrite_e_o;
  logic [15:0]     stall_cnt_o;
  logic [15:0]     flush_cnt_o;

  id_ex_stage #(.N(N), .RA_W(RA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .valid_d_i     (valid_d_i),
    .opcode_d_i    (opcode_d_i),
    .rd1_d_i       (rd1_d_i),
    .rd2_d_i       (rd2_d_i),
    .ra1_d_i       (ra1_d_i),
    .ra2_d_i       (ra2_d_i),
    .wa_d_i        (wa_d_i),
    .regwrite_d_i  (regwrite_d_i),
    .wa_m_i        (wa_m_i),
    .regwrite_m_i  (regwrite_m_i),
    .aluresult_m_i (aluresult_m_i),
    .wa_w_i        (wa_w_i),
    .regwrite_w_i  (regwrite_w_i),
    .result_w_i    (result_w_i),
    .valid_e_o     (valid_e_o),
    .opcode_e_o    (opcode_e_o),
    .a_e_o         (a_e_o),
    .b_e_o         (b_e_o),
    .wa_e_o        (wa_e_o),
    .regwrite_e_o  (regwrite_e_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic            v;
    logic [2:0]      op;
    logic [N-1:0]    rd1;
    logic [N-1:0]    rd2;
    logic [RA_W-1:0] ra1;
    logic [RA_W-1:0] ra2;
    logic [RA_W-1:0] wa;
    logic            rw;
  } slot_t;

  slot_t         ms;
  int            m_scnt;
  int            m_fcnt;
  logic [EW-1:0] exp_q[$];
  int            checks;
  int            errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Newest in-flight producer wins; the PC is architecturally not forwardable.
  function automatic logic [N-1:0] operand(input logic [RA_W-1:0] ra, input logic [N-1:0] held);
    if (ra == 4'd15) return held;
    if (regwrite_m_i && wa_m_i == ra) return aluresult_m_i;
    if (regwrite_w_i && wa_w_i == ra) return result_w_i;
    return held;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    valid_d_i = 1'b0; opcode_d_i = 3'b000; rd1_d_i = '0; rd2_d_i = '0;
    ra1_d_i = '0; ra2_d_i = '0; wa_d_i = '0; regwrite_d_i = 1'b0;
    regwrite_m_i = 1'b0; wa_m_i = '0; aluresult_m_i = '0;
    regwrite_w_i = 1'b0; wa_w_i = '0; result_w_i = '0;
  endtask

  task automatic drive_decode(input logic v, input logic [2:0] op, input logic [N-1:0] r1,
                              input logic [N-1:0] r2, input logic [RA_W-1:0] a1,
                              input logic [RA_W-1:0] a2, input logic [RA_W-1:0] w, input logic rw);
    valid_d_i = v; opcode_d_i = op; rd1_d_i = r1; rd2_d_i = r2;
    ra1_d_i = a1; ra2_d_i = a2; wa_d_i = w; regwrite_d_i = rw;
  endtask

  task automatic set_fwd(input logic rm, input logic [RA_W-1:0] am, input logic [N-1:0] dm,
                         input logic rw, input logic [RA_W-1:0] aw, input logic [N-1:0] dw);
    regwrite_m_i = rm; wa_m_i = am; aluresult_m_i = dm;
    regwrite_w_i = rw; wa_w_i = aw; result_w_i = dw;
  endtask

  // Compare all outputs against the model with the current forwarding inputs.
  task automatic check_outputs(input string tag);
    logic [EW-1:0] e;
    logic [15:0]   es;
    logic [15:0]   ef;
`ifdef ID_EX_PERF_CNT_EN
    es = 16'(m_scnt);
    ef = 16'(m_fcnt);
`else
    es = 16'h0000;
    ef = 16'h0000;
`endif
    exp_q.push_back({ms.v, ms.op, operand(ms.ra1, ms.rd1), operand(ms.ra2, ms.rd2),
                     ms.wa, ms.v & ms.rw, es, ef});
    e = exp_q.pop_front();
    check({tag, ".valid"},    valid_e_o,    e[EW-1]);
    check({tag, ".opcode"},   opcode_e_o,   e[EW-2 -: 3]);
    check({tag, ".a"},        a_e_o,        e[EW-5 -: N]);
    check({tag, ".b"},        b_e_o,        e[EW-5-N -: N]);
    check({tag, ".wa"},       wa_e_o,       e[EW-5-2*N -: RA_W]);
    check({tag, ".regwrite"}, regwrite_e_o, e[32]);
    check({tag, ".stall_cnt"}, stall_cnt_o, e[31:16]);
    check({tag, ".flush_cnt"}, flush_cnt_o, e[15:0]);
  endtask

  // Advance the model by the rules for one rising edge, then clock the DUT.
  task automatic step(input string tag);
    slot_t nx;
    nx = ms;
    if (rst) begin
      nx = '0;
      m_scnt = 0;
      m_fcnt = 0;
    end else if (flush_i) begin
      nx = '0;
      if (m_fcnt < 65535) m_fcnt++;
    end else if (stall_i) begin
      if (regwrite_w_i && wa_w_i == ms.ra1) nx.rd1 = result_w_i;
      if (regwrite_w_i && wa_w_i == ms.ra2) nx.rd2 = result_w_i;
      if (m_scnt < 65535) m_scnt++;
    end else begin
      nx = '{v: valid_d_i, op: opcode_d_i, rd1: rd1_d_i, rd2: rd2_d_i, ra1: ra1_d_i,
             ra2: ra2_d_i, wa: wa_d_i, rw: regwrite_d_i & valid_d_i};
    end
    @(posedge clk);
    ms = nx;
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [RA_W-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 4'd2;
      1:       return 4'd4;
      2:       return 4'd15;
      default: return RA_W'($urandom_range(0, 15));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; errors = 0; ms = '0; m_scnt = 0; m_fcnt = 0;
    set_idle();
    rst = 1'b1;
    step("reset");
    check("reset.valid_const", valid_e_o, 1'b0);
    rst = 1'b0;

    // Load path: SUB, no forwarding match
    drive_decode(1'b1, 3'b001, 32'd10, 32'd1, 4'd5, 4'd6, 4'd3, 1'b1);
    step("load");
    check("load.op_const", opcode_e_o, 3'b001);
    check("load.a_const", a_e_o, 32'd10);
    check("load.b_const", b_e_o, 32'd1);
    check("load.rw_const", regwrite_e_o, 1'b1);

    // MEM beats WB, then WB alone
    drive_decode(1'b1, 3'b000, 32'd0, 32'd0, 4'd2, 4'd2, 4'd6, 1'b1);
    set_fwd(1'b1, 4'd2, 32'd77, 1'b1, 4'd2, 32'd55);
    step("fwd_mem");
    check("fwd_mem.a_const", a_e_o, 32'd77);
    check("fwd_mem.b_const", b_e_o, 32'd77);
    regwrite_m_i = 1'b0;
    #1;
    check_outputs("fwd_wb");
    check("fwd_wb.a_const", a_e_o, 32'd55);
    check("fwd_wb.b_const", b_e_o, 32'd55);

    // R15 never forwarded
    drive_decode(1'b1, 3'b100, 32'd100, 32'd7, 4'd15, 4'd1, 4'd8, 1'b1);
    set_fwd(1'b1, 4'd15, 32'd9, 1'b1, 4'd15, 32'd11);
    step("r15");
    check("r15.a_const", a_e_o, 32'd100);

    // Stall with a WB write landing on the held ra2 in the first stall cycle
    set_fwd(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    drive_decode(1'b1, 3'b011, 32'd3, 32'd5, 4'd7, 4'd4, 4'd9, 1'b1);
    step("stall_load");
    stall_i = 1'b1;
    drive_decode(1'b1, 3'b010, 32'd999, 32'd888, 4'd1, 4'd1, 4'd1, 1'b0);
    set_fwd(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'd42);
    step("stall1");
    set_fwd(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    step("stall2");
    check("stall2.b_const", b_e_o, 32'd42);
    check("stall2.a_const", a_e_o, 32'd3);
    check("stall2.op_const", opcode_e_o, 3'b011);

    // Flush together with stall, from a clean reset
    stall_i = 1'b0;
    rst = 1'b1;
    step("rst2");
    rst = 1'b0;
    drive_decode(1'b1, 3'b001, 32'd1, 32'd2, 4'd1, 4'd2, 4'd3, 1'b1);
    step("pre_flush");
    flush_i = 1'b1; stall_i = 1'b1;
    step("flush_stall");
    check("flush.valid_const", valid_e_o, 1'b0);
    check("flush.rw_const", regwrite_e_o, 1'b0);
    check("flush.op_const", opcode_e_o, 3'b000);
`ifdef ID_EX_PERF_CNT_EN
    check("flush.fcnt_const", flush_cnt_o, 16'd1);
    check("flush.scnt_const", stall_cnt_o, 16'd0);
`endif

    // Reset mid-stream while stalled with valid contents
    flush_i = 1'b0; stall_i = 1'b0;
    drive_decode(1'b1, 3'b010, 32'd12, 32'd13, 4'd3, 4'd5, 4'd7, 1'b1);
    step("pre_rst");
    stall_i = 1'b1;
    step("stalled");
    rst = 1'b1;
    step("rst_mid");
    check("rst_mid.valid_const", valid_e_o, 1'b0);
    check("rst_mid.rw_const", regwrite_e_o, 1'b0);
    rst = 1'b0; stall_i = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      stall_i = ($urandom_range(0, 3) == 0);
      drive_decode(1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), $urandom, $urandom,
                   pick_addr(), pick_addr(), pick_addr(), 1'($urandom_range(0, 1)));
      set_fwd(1'($urandom_range(0, 1)), pick_addr(), $urandom,
              1'($urandom_range(0, 1)), pick_addr(), $urandom);
      step("rand");
      // Re-check the combinational forwarding path with fresh MEM/WB inputs.
      set_fwd(1'($urandom_range(0, 1)), pick_addr(), $urandom,
              1'($urandom_range(0, 1)), pick_addr(), $urandom);
      #1;
      check_outputs("rand_fwd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and the ALU in the RSA pipeline CPU.
- Latches the decoded opcode, operands and destination info, and inserts bubbles on flush.
- Holds its contents on stall and forwards from MEM/WB so the ALU gets current operands.
- Outputs drive the ALU's opcode_i, a_i and b_i directly.

Parameters:
- N, 32, datapath width (matches ALU N)
- RA_W, 4, register address width (16 architectural registers)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  hold current EX contents
- flush_i  in  1  replace EX contents with bubble
- valid_d_i  in  1  decode slot holds a real instruction
- opcode_d_i  in  3  decoded ALU opcode
- rd1_d_i  in  N  register-file read data, port 1
- rd2_d_i  in  N  register-file read data, port 2
- ra1_d_i  in  RA_W  source address, port 1
- ra2_d_i  in  RA_W  source address, port 2
- wa_d_i  in  RA_W  destination address
- regwrite_d_i  in  1  instruction writes a register
- wa_m_i  in  RA_W  MEM-stage destination address
- regwrite_m_i  in  1  MEM-stage write enable
- aluresult_m_i  in  N  MEM-stage ALU result
- wa_w_i  in  RA_W  WB-stage destination address
- regwrite_w_i  in  1  WB-stage write enable
- result_w_i  in  N  WB-stage write data
- valid_e_o  out  1  EX slot valid
- opcode_e_o  out  3  to ALU opcode_i
- a_e_o  out  N  to ALU a_i (forwarded)
- b_e_o  out  N  to ALU b_i (forwarded)
- wa_e_o  out  RA_W  EX destination address
- regwrite_e_o  out  1  EX write enable, gated by valid
- stall_cnt_o  out  16  stall-cycle count (see Optional Feature)
- flush_cnt_o  out  16  flush-cycle count (see Optional Feature)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all stored fields are 0, so valid_e_o=0, opcode_e_o=3'b000, wa_e_o=0 and regwrite_e_o=0. a_e_o and b_e_o are 0 unless forwarding matches.
- Registered fields: valid, opcode, rd1, rd2, ra1, ra2, wa, regwrite.
- Priority per rising edge: rst > flush_i > stall_i > load.
  - Flush: valid=0, regwrite=0, opcode=000; other fields don't-care, driven 0. flush_i together with stall_i gives a bubble.
  - Stall: all fields hold, except refresh: if regwrite_w_i and wa_w_i==stored ra1 (ra2), then stored rd1 (rd2) <= result_w_i. This stops a stalled instruction losing a WB value that retires during the stall.
  - Load: capture all *_d_i. regwrite is stored as regwrite_d_i & valid_d_i.
- Latency: one cycle, decode to EX outputs.
- Forwarding is combinational from stored fields, per operand (shown for a; b uses ra2/rd2):
  - If regwrite_m_i and wa_m_i==ra1 and ra1!=15: a = aluresult_m_i.
  - Else if regwrite_w_i and wa_w_i==ra1 and ra1!=15: a = result_w_i.
  - Else a = stored rd1.
- MEM has priority over WB (it is the newer value). R15 (PC) is never forwarded.
- Forwarding applies even when valid=0; the ALU result is ignored downstream because regwrite_e_o=0.
- Outputs: regwrite_e_o = stored regwrite & stored valid.
- Load-use hazard detection is not in this block; it is the upstream hazard unit's job, which drives stall_i/flush_i.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Two 16-bit counters, reset to 0.
  - stall_cnt_o increments on every cycle with stall_i=1 and flush_i=0.
  - flush_cnt_o increments on every cycle with flush_i=1.
  - Both saturate at 16'hFFFF.
- Undefined: no counter flops; both ports tied to 16'h0000.

Decomposition:
- Shared package cpu_pkg holds:
  - alu_op_t enum: ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, MOV=3'b100.
  - REG_ADDR_W=4, PC_REG=4'd15.
  - BUBBLE_OP=ADD.
- One sub-module, fwd_mux: combinational 3-way select with MEM>WB priority and R15 exclusion. Instantiated twice, once per operand.

Test Plan:
- Load path: rst, then valid_d=1, op=SUB, rd1=10, rd2=1, wa=3, regwrite=1, no fwd match. Next cycle: opcode_e=001, a=10, b=1, regwrite_e=1, valid_e=1.
- MEM forwarding priority: EX ra1=2 and ra2=2; regwrite_m=1, wa_m=2, aluresult_m=77; regwrite_w=1, wa_w=2, result_w=55. Required: a=77, b=77. With regwrite_m=0: a=55, b=55.
- R15 exclusion: ra1=15, rd1=100, regwrite_m=1, wa_m=15, aluresult_m=9. Required: a=100.
- Stall refresh: stall_i=1 for 2 cycles with stored ra2=4, rd2=5; WB writes r4=42 in the first stall cycle. Contents held, and b=42 after the WB value leaves the pipeline. d inputs changed during the stall are not captured.
- Flush vs stall: flush_i=1 and stall_i=1 together. Next cycle: valid_e=0, regwrite_e=0, opcode_e=000. With ID_EX_PERF_CNT_EN: flush_cnt=1, stall_cnt=0.
- Reset mid-stream: rst=1 while stall_i=1 with valid contents. Next cycle all outputs reset, and counters are 0 when the feature is enabled.
